// File: rtl/clk_pkg.sv
// rtl/clk_pkg.sv - shared types and helpers for the clock period meter
package clk_pkg;

  typedef enum logic {
    ACQUIRE,
    MEASURE
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - two-flop synchronizer plus history flop and any-edge pulse
module sync_edge_detect (
  input  logic clk_in,
  input  logic rst_n,
  input  logic sig_in,
  output logic edge_det,
  output logic level_prev
);

  logic sync1;
  logic sync2;
  logic hist;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign edge_det   = sync2 ^ hist;
  assign level_prev = hist;

endmodule

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - measures half-periods of a slow clock, tracks lock and stall
module clk_period_meter
  import clk_pkg::*;
#(
  parameter int EXPECTED_HALF_PERIOD = 20,
  parameter int COUNT_WIDTH          = 8,
  parameter int TOLERANCE            = 1,
  parameter int LOCK_COUNT           = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic                   sig_in,
  output logic [COUNT_WIDTH-1:0] half_period,
  output logic                   level,
  output logic                   meas_valid,
  output logic                   locked,
  output logic                   stall
);

  localparam int MW = clog2(LOCK_COUNT + 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [COUNT_WIDTH:0]   EXP_G     = (COUNT_WIDTH + 1)'(EXPECTED_HALF_PERIOD);
  localparam logic [COUNT_WIDTH:0]   TOL_G     = (COUNT_WIDTH + 1)'(TOLERANCE);
  localparam logic [MW-1:0]          MATCH_MAX = MW'(LOCK_COUNT);

  logic                   edge_det;
  logic                   level_prev;
  logic [COUNT_WIDTH-1:0] cnt;
  logic [MW-1:0]          match_cnt;
  state_t                 state;
  logic [COUNT_WIDTH:0]   meas;
  logic [COUNT_WIDTH:0]   diff;
  logic                   in_tol;

  sync_edge_detect u_sync (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .edge_det   (edge_det),
    .level_prev (level_prev)
  );

  // Guard bit keeps cnt+1 and the deviation from wrapping.
  always_comb begin
    meas   = {1'b0, cnt} + (COUNT_WIDTH + 1)'(1);
    diff   = (meas >= EXP_G) ? (meas - EXP_G) : (EXP_G - meas);
    in_tol = (diff <= TOL_G);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      match_cnt   <= '0;
      state       <= ACQUIRE;
      half_period <= '0;
      level       <= 1'b0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      stall       <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (edge_det) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + COUNT_WIDTH'(1);
      end

      case (state)
        ACQUIRE: begin
          if (edge_det) begin
            state <= MEASURE;
            stall <= 1'b0;
          end
        end
        MEASURE: begin
          if (edge_det) begin
            half_period <= meas[COUNT_WIDTH-1:0];
            level       <= level_prev;
            meas_valid  <= 1'b1;
            if (in_tol) begin
              if (match_cnt != MATCH_MAX) begin
                match_cnt <= match_cnt + MW'(1);
              end
              locked <= (match_cnt >= MATCH_MAX - MW'(1));
            end else begin
              match_cnt <= '0;
              locked    <= 1'b0;
            end
          end else if (cnt == CNT_MAX - COUNT_WIDTH'(1)) begin
            // An edge arriving this same cycle would have taken the branch above.
            stall     <= 1'b1;
            locked    <= 1'b0;
            match_cnt <= '0;
            state     <= ACQUIRE;
          end
        end
        default: state <= ACQUIRE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb/tb_clk_period_meter.sv - randomized bench with an event-level reference model
module tb_clk_period_meter;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       sig_in;
  logic [7:0] half_period;
  logic       level;
  logic       meas_valid;
  logic       locked;
  logic       stall;

  int n_tests = 0;
  int n_fail  = 0;
  bit cur     = 1'b0;

  clk_period_meter #(
    .EXPECTED_HALF_PERIOD (20),
    .COUNT_WIDTH          (8),
    .TOLERANCE            (1),
    .LOCK_COUNT           (4)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .sig_in      (sig_in),
    .half_period (half_period),
    .level       (level),
    .meas_valid  (meas_valid),
    .locked      (locked),
    .stall       (stall)
  );

  always #5 clk_in = ~clk_in;

  // Reference: sig_in samples at each rising edge; a change between samples
  // n-1 and n is reported at edge n+2 as a gap measured between event indices.
  bit   [3:0] h;
  int         t;
  int         last_ev;
  int         match;
  int         gap;
  int         dev;
  bit         measuring;
  logic [7:0] e_half;
  logic       e_level;
  logic       e_valid;
  logic       e_lock;
  logic       e_stall;

  always @(posedge clk_in) begin
    if (!rst_n) begin
      h = '0; t = 0; last_ev = 0; match = 0; measuring = 0;
      e_half = '0; e_level = 0; e_valid = 0; e_lock = 0; e_stall = 0;
    end else begin
      h = {h[2:0], sig_in};
      e_valid = 0;
      if (h[2] != h[3]) begin
        if (measuring) begin
          gap     = (t - 2) - last_ev;
          e_half  = gap[7:0];
          e_level = h[3];
          e_valid = 1;
          dev     = (gap > 20) ? gap - 20 : 20 - gap;
          if (dev <= 1) begin
            match  = (match < 4) ? match + 1 : 4;
            e_lock = (match == 4);
          end else begin
            match  = 0;
            e_lock = 0;
          end
        end else begin
          measuring = 1;
          e_stall   = 0;
        end
        last_ev = t - 2;
      end else if (measuring && t == last_ev + 257) begin
        e_stall   = 1;
        e_lock    = 0;
        match     = 0;
        measuring = 0;
      end
      t = t + 1;
    end
    #1;
    n_tests = n_tests + 1;
    if ({meas_valid, half_period, level, locked, stall} !== {e_valid, e_half, e_level, e_lock, e_stall}) begin
      n_fail = n_fail + 1;
      $display("FAIL cycle_check t=%0d got v=%b hp=%0d lv=%b lk=%b st=%b want v=%b hp=%0d lv=%b lk=%b st=%b",
               t, meas_valid, half_period, level, locked, stall,
               e_valid, e_half, e_level, e_lock, e_stall);
    end
  end

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic hold(input bit v, input int n);
    sig_in = v;
    cur    = v;
    repeat (n) @(negedge clk_in);
  endtask

  task automatic toggles(input int count, input int hp);
    for (int i = 0; i < count; i++) hold(~cur, hp);
  endtask

  initial begin
    int r;
    int hp;
    rst_n  = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check_lit("reset_outputs", {half_period, level, meas_valid, locked, stall}, 0);
    rst_n = 1'b1;
    hold(0, 5);

    // nominal lock: first edge acquires, 4th report locks
    toggles(6, 20);
    check_lit("nominal_half", half_period, 20);
    check_lit("nominal_level", level, 1);
    check_lit("nominal_locked", locked, 1);

    // jitter within tolerance, then one out-of-tolerance interval
    hold(1, 19); hold(0, 21); hold(1, 20); hold(0, 21);
    check_lit("jitter_locked", locked, 1);
    hold(1, 22); hold(0, 20);
    check_lit("jitter22_half", half_period, 22);
    check_lit("jitter22_unlocked", locked, 0);
    toggles(6, 20);
    check_lit("relock", locked, 1);

    // stall after lock
    hold(cur, 300);
    check_lit("stall_set", stall, 1);
    check_lit("stall_unlocked", locked, 0);
    hold(~cur, 20);
    check_lit("stall_cleared", stall, 0);
    check_lit("stall_no_report", half_period, 20);
    hold(~cur, 20);

    // asymmetric duty
    for (int i = 0; i < 4; i++) begin
      hold(1, 10);
      hold(0, 30);
    end
    check_lit("asym_high_half", half_period, 10);
    check_lit("asym_high_level", level, 1);
    check_lit("asym_unlocked", locked, 0);
    hold(1, 10);
    check_lit("asym_low_half", half_period, 30);
    check_lit("asym_low_level", level, 0);

    // reset while locked, between edges
    toggles(6, 20);
    hold(~cur, 10);
    check_lit("locked_before_reset", locked, 1);
    rst_n = 1'b0;
    #1;
    check_lit("async_reset_outputs", {half_period, level, meas_valid, locked, stall}, 0);
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    hold(cur, 5);
    toggles(4, 20);
    check_lit("post_reset_not_locked", locked, 0);
    toggles(2, 20);
    check_lit("post_reset_relock", locked, 1);

    // glitch on a low signal
    hold(0, 40); hold(1, 2); hold(0, 40);
    check_lit("glitch_half", half_period, 2);
    check_lit("glitch_level", level, 1);
    check_lit("glitch_unlocked", locked, 0);

    // randomized intervals including short pulses and stalls
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 19);
      if (r < 14)      hp = $urandom_range(18, 22);
      else if (r < 18) hp = $urandom_range(1, 6);
      else             hp = $urandom_range(250, 262);
      hold(~cur, hp);
    end
    hold(cur, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
